// File: rtl/count_sampler.sv
// Sample FIFO for a free-running counter: each accepted capture stores {wrap, count},
// where wrap flags a value lower than the previously accepted one. Drops are counted.
module count_sampler #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             capture,
  input  logic             out_ready,
  input  logic             clear_ovf,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_wrap,
  output logic             full,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  // Handshake: a sample moves downstream on a rising edge where out_valid && out_ready;
  // out_data/out_wrap hold the oldest entry and stay stable until that edge.

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [WIDTH-1:0] last_count;

  logic             pop;
  logic             push;
  logic             drop;
  logic             new_wrap;
  logic             head_from_new;
  logic [AW-1:0]    rd_next;
  logic [OW-1:0]    occ_next;

  assign out_valid = (occ != '0);
  assign full      = (occ == OW'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = capture && (!full || pop);
  assign drop      = capture && !push;
  assign new_wrap  = (count < last_count);
  assign rd_next   = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + OW'(1);
      2'b01:   occ_next = occ - OW'(1);
      default: occ_next = occ;
    endcase
  end

  // A push that leaves exactly one entry is the new head and bypasses the array.
  assign head_from_new = push && (occ_next == OW'(1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {new_wrap, count};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      out_data   <= '0;
      out_wrap   <= 1'b0;
      last_count <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      rd_ptr <= rd_next;
      occ    <= occ_next;
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_count <= count;
      end
      if (head_from_new) begin
        {out_wrap, out_data} <= {new_wrap, count};
      end else if (occ_next != '0) begin
        {out_wrap, out_data} <= mem[rd_next];
      end
      // A drop on the same edge as clear_ovf leaves one recorded drop.
      if (drop) begin
        overflow <= 1'b1;
        if (clear_ovf) begin
          drop_count <= 8'd1;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end else if (clear_ovf) begin
        overflow   <= 1'b0;
        drop_count <= 8'd0;
      end
    end
  end

endmodule
